// File: rtl/multi_pkg.sv
// Shared types and constants for the multiplier-product BCD converter.
package multi_pkg;

    localparam int MULT_W     = 4;
    localparam int PROD_W     = 8;
    localparam int BCD_DIGITS = 3;

    localparam logic [3:0] DD_THRESH = 4'd5;
    localparam logic [3:0] DD_ADJ    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Double-dabble correction for one nibble. The add is 4-bit and
    // deliberately discards any carry: a nibble never exceeds 9 before
    // the adjust, so the result fits.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= DD_THRESH) ? (nib + DD_ADJ) : nib;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3-if->=5 correction for a single BCD digit.
module bcd_digit_adj
    import multi_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = dd_adjust(i_digit);

endmodule

// File: rtl/multi_product_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one shift per cycle)
// with valid/ready handshakes on both the product input and BCD output.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a product; in_ready follows ena
// SHIFT | conversion running; one adjust+shift per enabled cycle
// DONE  | out_bcd holds the result; waiting for out_ready
module multi_product_bcd
    import multi_pkg::*;
#(
    parameter int WIDTH  = PROD_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [WIDTH-1:0]      in_product,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // The BCD field must be able to hold the largest binary input.
    generate
        if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_bad_digits
            $error("multi_product_bcd: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic [SR_W-1:0]    r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic [SR_W-1:0]    w_adj;
    logic [SR_W-1:0]    w_shifted;
    logic               w_accept;
    logic               w_last;

    // Binary part passes through untouched; every BCD nibble is corrected
    // in parallel before the shift.
    assign w_adj[WIDTH-1:0] = r_shift[WIDTH-1:0];

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_shift[WIDTH + 4*g +: 4]),
                .o_digit (w_adj[WIDTH + 4*g +: 4])
            );
        end
    endgenerate

    assign w_shifted = {w_adj[SR_W-2:0], 1'b0};
    assign out_bcd   = r_bcd;

    // Next-state and handshake outputs; ena gates every transition.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ena;
                w_accept = ena & in_valid;
                if (w_accept) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy   = 1'b1;
                w_last = (r_cnt == CNT_W'(1));
                if (ena && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (ena && out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register; reset wins over ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_next_state;
        end
    end

    // Shift register, iteration counter and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= {{BCD_W{1'b0}}, in_product};
                        r_cnt   <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    r_shift <= w_shifted;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    // Result is taken from the post-shift value so it is
                    // visible in the same cycle the FSM enters DONE.
                    if (w_last) begin
                        r_bcd <= w_shifted[SR_W-1:WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_product_bcd.sv
// Directed, table-driven bench for multi_product_bcd.
module tb_multi_product_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  in_product;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_bcd;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  prod;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    multi_product_bcd dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_product (in_product),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_bcd    (out_bcd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [11:0] bcd_model(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    // Called at a negedge with the DUT idle and ena high; returns at the
    // negedge where out_valid is first seen.
    task automatic convert(input logic [7:0] val, output logic [11:0] res,
                           output int lat, output int busy_cyc);
        in_product = val;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("conv_timeout", out_valid, 1);
        res = out_bcd;
        check("nibble_range", (res[11:8] <= 9 && res[7:4] <= 9 && res[3:0] <= 9), 1);
    endtask

    task automatic to_idle();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] res;
        int lat, bcyc, bad, cyc;

        vecs[0]  = '{8'd0,   12'h000};
        vecs[1]  = '{8'd1,   12'h001};
        vecs[2]  = '{8'd9,   12'h009};
        vecs[3]  = '{8'd10,  12'h010};
        vecs[4]  = '{8'd59,  12'h059};
        vecs[5]  = '{8'd99,  12'h099};
        vecs[6]  = '{8'd100, 12'h100};
        vecs[7]  = '{8'd127, 12'h127};
        vecs[8]  = '{8'd128, 12'h128};
        vecs[9]  = '{8'd199, 12'h199};
        vecs[10] = '{8'd254, 12'h254};
        vecs[11] = '{8'd255, 12'h255};

        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_product = 8'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_bcd", out_bcd, 12'h000);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // 225: latency and busy duration
        convert(8'd225, res, lat, bcyc);
        check("p225_bcd", res, 12'h225);
        check("p225_latency", lat, 8);
        check("p225_busy_cycles", bcyc, 8);
        check("p225_in_ready_done", in_ready, 0);
        to_idle();
        check("p225_release", out_valid, 0);

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].prod, res, lat, bcyc);
            check($sformatf("vec_%0d", vecs[i].prod), res, vecs[i].exp);
            to_idle();
        end

        for (int v = 0; v < 256; v++) begin
            convert(8'(v), res, lat, bcyc);
            check($sformatf("sweep_%0d", v), res, bcd_model(v));
            to_idle();
        end

        // Backpressure on 144, with a competing input held valid
        out_ready = 1'b0;
        convert(8'd144, res, lat, bcyc);
        check("bp_bcd", res, 12'h144);
        in_valid = 1'b1;
        in_product = 8'd99;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || out_bcd !== 12'h144 || in_ready) bad++;
        end
        check("bp_hold", bad, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_out_valid_drop", out_valid, 0);
        check("bp_in_ready", in_ready, 1);
        check("bp_bcd_retained", out_bcd, 12'h144);

        // ena stall of 5 cycles after the third shift
        in_product = 8'd57;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        ena = 1'b0;
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (in_ready || !busy || out_valid || out_bcd !== 12'h144) bad++;
        end
        check("stall_frozen", bad, 0);
        ena = 1'b1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("stall_latency", cyc, 13);
        check("stall_bcd", out_bcd, 12'h057);
        to_idle();

        // Reset after four shifts
        in_product = 8'd200;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bcd", out_bcd, 12'h000);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        convert(8'd36, res, lat, bcyc);
        check("after_rst_bcd", res, 12'h036);
        to_idle();

        // in_valid held high with changing data through SHIFT and DONE
        out_ready = 1'b0;
        in_product = 8'd77;
        in_valid = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 100) begin
            in_product = in_product + 8'd13;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("hold_valid_bcd", out_bcd, 12'h077);
        repeat (3) begin
            in_product = in_product + 8'd7;
            @(posedge clk);
            @(negedge clk);
        end
        check("hold_valid_done_bcd", out_bcd, 12'h077);
        in_product = 8'd88;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_valid_idle_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("next_latency", lat, 8);
        check("next_bcd", out_bcd, 12'h088);
        to_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
